// File: rtl/rq_arbiter.sv
// Two-requester round-robin arbiter in front of the RQ formatter.
// A grant is held for a whole packet (sop through last); per-requester packet counters and a sticky protocol-error flag are kept.
module rq_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_sop,
  input  logic [1:0]              req_last,
  input  logic [7:0]              req_type,
  input  logic [127:0]            req_addr,
  input  logic [21:0]             req_dword_count,
  input  logic [15:0]             req_tag,
  input  logic [5:0]              req_tc,
  input  logic [2*DATA_WIDTH-1:0] req_wr_data,
  input  logic [2*KEEP_WIDTH-1:0] req_wr_data_keep,
  input  logic                    rq_ready,
  output logic                    rq_valid,
  output logic                    rq_sop,
  output logic                    rq_last,
  output logic [3:0]              rq_type,
  output logic [63:0]             rq_addr,
  output logic [10:0]             rq_dword_count,
  output logic [7:0]              rq_tag,
  output logic [2:0]              rq_tc,
  output logic [DATA_WIDTH-1:0]   rq_wr_data,
  output logic [KEEP_WIDTH-1:0]   rq_wr_data_keep,
  output logic                    grant_id,
  output logic                    busy,
  output logic [15:0]             pkt_cnt0,
  output logic [15:0]             pkt_cnt1,
  output logic                    err_no_sop
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant_id;
  logic        w_grant_nxt;
  logic        r_last_served;
  logic [15:0] r_pkt_cnt0;
  logic [15:0] r_pkt_cnt1;
  logic        r_err_no_sop;

  logic [1:0]  w_eligible;
  logic [1:0]  w_no_sop;
  logic        w_xfer;
  logic        w_done;

  // Per-requester views of the packed input buses, indexed by grant id.
  logic [1:0][3:0]            w_type;
  logic [1:0][63:0]           w_addr;
  logic [1:0][10:0]           w_dword_count;
  logic [1:0][7:0]            w_tag;
  logic [1:0][2:0]            w_tc;
  logic [1:0][DATA_WIDTH-1:0] w_wr_data;
  logic [1:0][KEEP_WIDTH-1:0] w_wr_data_keep;

  assign w_type         = req_type;
  assign w_addr         = req_addr;
  assign w_dword_count  = req_dword_count;
  assign w_tag          = req_tag;
  assign w_tc           = req_tc;
  assign w_wr_data      = req_wr_data;
  assign w_wr_data_keep = req_wr_data_keep;

  assign w_eligible = req_valid & req_sop;
  assign w_no_sop   = req_valid & ~req_sop;
  assign w_xfer     = (r_state == S_LOCKED) && req_valid[r_grant_id] && rq_ready;
  assign w_done     = w_xfer && req_last[r_grant_id];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt = S_LOCKED;
          // Contention goes to whoever was not served last.
          if (&w_eligible) w_grant_nxt = ~r_last_served;
          else             w_grant_nxt = w_eligible[1];
        end
      end
      S_LOCKED: begin
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rq_valid        = 1'b0;
    rq_sop          = 1'b0;
    rq_last         = 1'b0;
    rq_type         = '0;
    rq_addr         = '0;
    rq_dword_count  = '0;
    rq_tag          = '0;
    rq_tc           = '0;
    rq_wr_data      = '0;
    rq_wr_data_keep = '0;
    req_ready       = 2'b00;
    if (r_state == S_LOCKED) begin
      rq_valid        = req_valid[r_grant_id];
      rq_sop          = req_sop[r_grant_id];
      rq_last         = req_last[r_grant_id];
      rq_type         = w_type[r_grant_id];
      rq_addr         = w_addr[r_grant_id];
      rq_dword_count  = w_dword_count[r_grant_id];
      rq_tag          = w_tag[r_grant_id];
      rq_tc           = w_tc[r_grant_id];
      rq_wr_data      = w_wr_data[r_grant_id];
      rq_wr_data_keep = w_wr_data_keep[r_grant_id];
      req_ready[r_grant_id] = rq_ready;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant_id    <= 1'b0;
      r_last_served <= 1'b1;
      r_pkt_cnt0    <= '0;
      r_pkt_cnt1    <= '0;
      r_err_no_sop  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      if (w_done) begin
        r_last_served <= r_grant_id;
        if (r_grant_id) r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
        else            r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
      end
      if ((r_state == S_IDLE) && (|w_no_sop)) r_err_no_sop <= 1'b1;
    end
  end

  assign grant_id   = r_grant_id;
  assign busy       = (r_state == S_LOCKED);
  assign pkt_cnt0   = r_pkt_cnt0;
  assign pkt_cnt1   = r_pkt_cnt1;
  assign err_no_sop = r_err_no_sop;

endmodule
